lutn_cfg_reg: RTL

Runtime-reconfigurable N-input LUT with registered output, for the PP3 feature/install tests. Generalises the fixed 3-input LUT test design: input width is parametrised, and the truth table resets to a parameter value but can be replaced at runtime over a serial valid/ready load port. The new table is committed atomically. Intended as a DUT for post-route timing simulation (SDF) and for fabric bring-up of logic plus FF packing.

---
 rtl/lutn_cfg_pkg.sv | 28 ++
 rtl/lutn_cfg_if.sv | 30 +++
 rtl/lutn_cfg_shift.sv | 60 ++++++
 rtl/lutn_cfg_reg.sv | 123 ++++++++++++
 4 files changed

// File: rtl/lutn_cfg_pkg.sv
// Shared definitions for the reconfigurable LUT (lutn_cfg_reg).
//   - FSM state encodings (legacy localparam constants) and the state enum
//   - default reset truth table for the 3-input case
//   - tt_size(n): number of truth-table bits for an n-input LUT
// Optional feature macro: LUTN_CFG_PARITY_EN (PARITY state is only used when
// it is defined; the encoding is reserved either way).
package lutn_cfg_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    PARITY = ST_PARITY,
    COMMIT = ST_COMMIT
  } state_e;

  // 000->1, 001->1, 111->1, everything else 0.
  localparam logic [7:0] LUTN_DEFAULT_INIT = 8'h83;

  function automatic int tt_size(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/lutn_cfg_if.sv
// Serial truth-table load port of lutn_cfg_reg.
//   cfg_start : pulse, begins or restarts a load        (master -> slave)
//   cfg_valid : cfg_bit is valid                        (master -> slave)
//   cfg_bit   : serial table bit, index 0 first         (master -> slave)
//   cfg_ready : slave accepts a bit this cycle          (slave -> master)
//   cfg_done  : one-cycle pulse, new table committed    (slave -> master)
//   cfg_err   : one-cycle pulse, load rejected          (slave -> master)
//               present only with LUTN_CFG_PARITY_EN
interface lutn_cfg_if;

  logic cfg_start;
  logic cfg_valid;
  logic cfg_bit;
  logic cfg_ready;
  logic cfg_done;
`ifdef LUTN_CFG_PARITY_EN
  logic cfg_err;

  modport master (output cfg_start, cfg_valid, cfg_bit,
                  input  cfg_ready, cfg_done, cfg_err);
  modport slave  (input  cfg_start, cfg_valid, cfg_bit,
                  output cfg_ready, cfg_done, cfg_err);
`else
  modport master (output cfg_start, cfg_valid, cfg_bit,
                  input  cfg_ready, cfg_done);
  modport slave  (input  cfg_start, cfg_valid, cfg_bit,
                  output cfg_ready, cfg_done);
`endif

endinterface

// File: rtl/lutn_cfg_shift.sv
// Shadow shift register for a truth-table load.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : drop any partial load (count, shadow, parity back to zero)
//   shift_en  : store cfg_bit at shadow[count] and advance count
//   cfg_bit   : incoming serial bit
//   shadow    : table being assembled
//   full      : the transfer happening this cycle completes the table
//   parity_ok : (LUTN_CFG_PARITY_EN only) cfg_bit taken as the parity bit
//               gives even parity over shadow plus that bit
module lutn_cfg_shift
  import lutn_cfg_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic                  cfg_bit,
  output logic [tt_size(N)-1:0] shadow,
`ifdef LUTN_CFG_PARITY_EN
  output logic                  parity_ok,
`endif
  output logic                  full
);

  localparam int SIZE = tt_size(N);
  localparam int CW   = $clog2(SIZE) + 1;

  logic [CW-1:0] count;
`ifdef LUTN_CFG_PARITY_EN
  logic          acc;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count  <= '0;
      shadow <= '0;
`ifdef LUTN_CFG_PARITY_EN
      acc    <= 1'b0;
`endif
    end else if (shift_en) begin
      shadow[count[CW-2:0]] <= cfg_bit;
      count                 <= count + 1'b1;
`ifdef LUTN_CFG_PARITY_EN
      acc                   <= acc ^ cfg_bit;
`endif
    end
  end

  // Combinational so the FSM leaves LOAD on the same edge as the last bit.
  assign full = shift_en && (count == CW'(SIZE - 1));

`ifdef LUTN_CFG_PARITY_EN
  assign parity_ok = ~(acc ^ cfg_bit);
`endif

endmodule

// File: rtl/lutn_cfg_reg.sv
// Runtime-reconfigurable N-input LUT with registered output.
//   clk, rst : clock, synchronous active-high reset
//   I        : LUT select inputs (unsigned index into the table)
//   O        : registered LUT output, O <= table[I] every edge
//   cfg      : serial load port (lutn_cfg_if.slave); a full load is shifted
//              into a shadow and committed atomically.
// Optional feature macro: LUTN_CFG_PARITY_EN adds a trailing even-parity bit
// per load, the PARITY state and cfg_err; a bad load leaves the table as is.
module lutn_cfg_reg
  import lutn_cfg_pkg::*;
#(
  parameter int                    N    = 3,
  parameter logic [tt_size(N)-1:0] INIT = LUTN_DEFAULT_INIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] I,
  output logic         O,
  lutn_cfg_if.slave    cfg
);

  localparam int SIZE = tt_size(N);

  state_e            state_q;
  logic [SIZE-1:0]   table_q;
  logic [SIZE-1:0]   shadow;
  logic              full;
  logic              ready;
  logic              xfer;
  logic              clear;
  logic              shift_en;
  logic              done_q;
`ifdef LUTN_CFG_PARITY_EN
  logic              parity_ok;
  logic              err_q;
`endif

  // cfg_ready is a pure state decode; it is the only unregistered output.
`ifdef LUTN_CFG_PARITY_EN
  assign ready = (state_q == LOAD) || (state_q == PARITY);
`else
  assign ready = (state_q == LOAD);
`endif

  // A start pulse takes priority over a bit offered in the same cycle.
  assign xfer     = cfg.cfg_valid && ready && !cfg.cfg_start;
  assign clear    = cfg.cfg_start && (state_q != COMMIT);
  assign shift_en = xfer && (state_q == LOAD);

  lutn_cfg_shift #(.N(N)) u_shift (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .shift_en  (shift_en),
    .cfg_bit   (cfg.cfg_bit),
    .shadow    (shadow),
`ifdef LUTN_CFG_PARITY_EN
    .parity_ok (parity_ok),
`endif
    .full      (full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      // The table is a register, not a RAM: reset restores INIT even after a
      // runtime table was committed.
      state_q <= IDLE;
      table_q <= INIT;
      O       <= 1'b0;
      done_q  <= 1'b0;
`ifdef LUTN_CFG_PARITY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      // Lookup runs in every state; during COMMIT it still sees the old table.
      O      <= table_q[I];
      done_q <= 1'b0;
`ifdef LUTN_CFG_PARITY_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (cfg.cfg_start) state_q <= LOAD;
        end
        LOAD: begin
          // A restart keeps us in LOAD; the shifter clears itself.
`ifdef LUTN_CFG_PARITY_EN
          if (full) state_q <= PARITY;
`else
          if (full) state_q <= COMMIT;
`endif
        end
`ifdef LUTN_CFG_PARITY_EN
        PARITY: begin
          if (cfg.cfg_start) begin
            state_q <= LOAD;
          end else if (xfer) begin
            if (parity_ok) begin
              state_q <= COMMIT;
            end else begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
`endif
        COMMIT: begin
          table_q <= shadow;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg.cfg_ready = ready;
  assign cfg.cfg_done  = done_q;
`ifdef LUTN_CFG_PARITY_EN
  assign cfg.cfg_err   = err_q;
`endif

endmodule
